// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter granting N requesters write access to one W-bit register.
// Optional REG_ARB_LOCK_EN adds a lock input that lets the last writer keep the next grant.
module reg_write_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic           ack,
  output logic [W-1:0]   q,
  output logic           busy
`ifdef REG_ARB_LOCK_EN
  ,
  input  logic [N-1:0]   lock
`endif
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [N-1:0]  r_gnt;
  logic [W-1:0]  r_q;
  logic [LW-1:0] r_last;
  logic [LW-1:0] r_win;

  logic          w_found;
  logic [LW-1:0] w_pick;
  logic [LW:0]   w_sum;
  logic [N-1:0]  w_onehot;
  logic [W-1:0]  w_slice;

`ifdef REG_ARB_LOCK_EN
  logic          r_locked;
  logic [LW-1:0] r_lock_own;
`endif

  // Round-robin search upward from last+1, wrapping; a held lock overrides.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int k = 1; k <= N; k++) begin
      w_sum = {1'b0, r_last} + (LW+1)'(k);
      if (w_sum >= (LW+1)'(N)) begin
        w_sum = w_sum - (LW+1)'(N);
      end
      if (!w_found && req[w_sum[LW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[LW-1:0];
      end
    end
`ifdef REG_ARB_LOCK_EN
    if (r_locked && req[r_lock_own]) begin
      w_pick = r_lock_own;
    end
`endif
  end

  assign w_onehot = N'(1) << w_pick;

  // Select the winner's data slice for the GRANT->ACK capture.
  always_comb begin
    w_slice = '0;
    for (int i = 0; i < N; i++) begin
      if (r_win == LW'(i)) begin
        w_slice = wdata[i*W +: W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: one write takes exactly three cycles.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_found ? GRANT : IDLE;
      GRANT:   w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Grant, winner, rotation pointer and shared register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt      <= '0;
      r_q        <= '0;
      r_last     <= LW'(N-1);
      r_win      <= '0;
`ifdef REG_ARB_LOCK_EN
      r_locked   <= 1'b0;
      r_lock_own <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_gnt    <= w_onehot;
            r_win    <= w_pick;
`ifdef REG_ARB_LOCK_EN
            r_locked <= 1'b0;
`endif
          end
        end
        GRANT: begin
          r_q <= w_slice;
        end
        ACK: begin
          r_last     <= r_win;
          r_gnt      <= '0;
`ifdef REG_ARB_LOCK_EN
          r_locked   <= lock[r_win];
          r_lock_own <= r_win;
`endif
        end
        default: begin
          r_gnt <= '0;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign q    = r_q;
  assign ack  = (r_state == ACK);
  assign busy = (r_state != IDLE);

endmodule
